// File: rtl/dram_burst_ctrl.sv
// Two-requester round-robin burst controller in front of the DRAM array.
// One grant covers one BURST_LEN-beat read or write burst at incrementing addresses.
module dram_burst_ctrl #(
   parameter int ADDR_W    = 13,
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        req_we,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic              wdata_pull,
   output logic              rdata_valid,
   output logic              rdata_id,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                dir_q, dir_d;
   logic                id_q, id_d;
   logic                prio_q, prio_d;
   logic                rvld_q, rvld_d;
   logic                win;
   logic                last_beat;

   // prio_q names the requester that wins a tie; it flips away from whoever finished last
   assign win       = (req == 2'b11) ? prio_q : req[1];
   assign last_beat = (beat_q == CNT_W'(BURST_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         base_q  <= '0;
         dir_q   <= 1'b0;
         id_q    <= 1'b0;
         prio_q  <= 1'b0;
         rvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         dir_q   <= dir_d;
         id_q    <= id_d;
         prio_q  <= prio_d;
         rvld_q  <= rvld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      base_d  = base_q;
      dir_d   = dir_q;
      id_d    = id_q;
      prio_d  = prio_q;
      case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               base_d  = win ? req_addr1 : req_addr0;
               dir_d   = req_we[win];
               id_d    = win;
               beat_d  = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            beat_d = beat_q + 1'b1;
            if (last_beat) begin
               beat_d  = '0;
               state_d = dir_q ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE: begin
            prio_d  = ~id_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy       = (state_q != S_IDLE);
   assign gnt        = busy ? (id_q ? 2'b10 : 2'b01) : 2'b00;
   assign done       = (state_q == S_DONE);
   assign mem_en     = (state_q == S_BURST);
   assign mem_we     = mem_en & dir_q;
   assign mem_addr   = mem_en ? (base_q + ADDR_W'(beat_q)) : '0;
   assign wdata_pull = mem_we;
   assign mem_wdata  = mem_we ? (id_q ? wdata1 : wdata0) : '0;

   // The array answers one cycle after the strobe, so the valid flag trails mem_en by one register
   assign rvld_d      = mem_en & ~mem_we;
   assign rdata_valid = rvld_q;
   assign rdata       = rvld_q ? mem_rdata : '0;
   assign rdata_id    = rvld_q & id_q;

endmodule

// File: tb/tb_dram_burst_ctrl.sv
// Bench for dram_burst_ctrl: vector table of transactions plus hand sequences,
// with a beat/read-data scoreboard fed at stimulus time and drained by a monitor.
module tb_dram_burst_ctrl;

   localparam int AW = 13;
   localparam int DW = 64;
   localparam int BL = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    req = 2'b00;
   logic [1:0]    req_we = 2'b00;
   logic [AW-1:0] req_addr0 = '0;
   logic [AW-1:0] req_addr1 = '0;
   logic [DW-1:0] wdata0, wdata1;
   logic [1:0]    gnt;
   logic          wdata_pull, rdata_valid, rdata_id, done, busy, mem_en, mem_we;
   logic [DW-1:0] rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [AW-1:0] mem_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wd;
   } beat_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          id;
   } rd_t;

   typedef struct {
      logic [1:0]    req;
      logic [1:0]    we;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic          id;
   } vec_t;

   beat_t exp_q[$];
   rd_t   rd_q[$];
   logic [DW-1:0] mem    [logic [AW-1:0]];
   logic [DW-1:0] shadow [logic [AW-1:0]];
   int unsigned wcnt0 = 0;
   int unsigned wcnt1 = 0;

   dram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .wdata_pull(wdata_pull),
      .rdata_valid(rdata_valid), .rdata_id(rdata_id), .rdata(rdata),
      .done(done), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(input logic id, input int unsigned n);
      return (id ? 64'hBBBB_0000_0000_0000 : 64'hAAAA_0000_0000_0000) ^ 64'(n * 32'h0001_0003);
   endfunction

   assign wdata0 = pat(1'b0, wcnt0);
   assign wdata1 = pat(1'b1, wcnt1);

   // requesters advance their write data after each pull
   always @(posedge clk) begin
      if (wdata_pull && gnt[0]) wcnt0 <= wcnt0 + 1;
      if (wdata_pull && gnt[1]) wcnt1 <= wcnt1 + 1;
   end

   // array model: write on strobe, read data one cycle later
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
      mem_rdata <= (mem_en && !mem_we) ? (mem.exists(mem_addr) ? mem[mem_addr] : '0) : '0;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : mon
      beat_t b;
      rd_t   r;
      if (mem_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%h expected=none", mem_addr);
         end else begin
            b = exp_q.pop_front();
            chk("mem_addr", 64'(mem_addr), 64'(b.addr));
            chk("mem_we", 64'(mem_we), 64'(b.we));
            chk("mem_wdata", mem_wdata, b.wd);
         end
      end
      if (rdata_valid) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rdata actual=%h expected=none", rdata);
         end else begin
            r = rd_q.pop_front();
            chk("rdata", rdata, r.d);
            chk("rdata_id", 64'(rdata_id), 64'(r.id));
         end
      end
   end

   task automatic push_beats(input logic id, input logic we, input logic [AW-1:0] base,
                             input bit upd);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      rd_t r;
      for (int k = 0; k < BL; k++) begin
         a = base + AW'(k);
         d = we ? pat(id, (id ? wcnt1 : wcnt0) + k) : '0;
         exp_q.push_back('{addr: a, we: we, wd: d});
         if (we && upd) shadow[a] = d;
         if (!we) begin
            r.d  = shadow.exists(a) ? shadow[a] : '0;
            r.id = id;
            rd_q.push_back(r);
         end
      end
   endtask

   // Caller applies inputs during the idle cycle T, before its falling edge.
   task automatic do_txn(input logic id, input logic we, input logic [AW-1:0] base,
                         input bit hold, input int drop_c);
      int done_c;
      int pulls;
      logic [1:0] oh;
      oh     = id ? 2'b10 : 2'b01;
      done_c = we ? BL + 1 : BL + 2;
      pulls  = 0;
      push_beats(id, we, base, 1'b1);
      for (int c = 0; c <= done_c; c++) begin
         @(negedge clk);
         chk("busy", 64'(busy), 64'(c >= 1));
         chk("gnt", 64'(gnt), 64'((c >= 1) ? oh : 2'b00));
         chk("done", 64'(done), 64'(c == done_c));
         chk("mem_en", 64'(mem_en), 64'(c >= 1 && c <= BL));
         chk("rdata_valid", 64'(rdata_valid), 64'(!we && c >= 2 && c <= BL + 1));
         if (wdata_pull) pulls++;
         if (c == drop_c) req = 2'b00;
      end
      chk("pull_count", 64'(pulls), 64'(we ? BL : 0));
      if (!hold) begin
         @(posedge clk);
         #1 req = 2'b00;
      end
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{req: 2'b01, we: 2'b01, a0: 13'h0010, a1: 13'h0000, id: 1'b0};
      vecs[1] = '{req: 2'b10, we: 2'b10, a0: 13'h0000, a1: 13'h0100, id: 1'b1};
      vecs[2] = '{req: 2'b10, we: 2'b00, a0: 13'h0000, a1: 13'h0100, id: 1'b1};
      vecs[3] = '{req: 2'b01, we: 2'b01, a0: 13'h1FFC, a1: 13'h0000, id: 1'b0};
      vecs[4] = '{req: 2'b01, we: 2'b00, a0: 13'h1FFC, a1: 13'h0000, id: 1'b0};
      vecs[5] = '{req: 2'b11, we: 2'b00, a0: 13'h0010, a1: 13'h0200, id: 1'b1};
      vecs[6] = '{req: 2'b11, we: 2'b11, a0: 13'h0020, a1: 13'h0210, id: 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_mem_en", 64'(mem_en), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rvld", 64'(rdata_valid), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         req_we    = vecs[i].we;
         req_addr0 = vecs[i].a0;
         req_addr1 = vecs[i].a1;
         req       = vecs[i].req;
         do_txn(vecs[i].id, vecs[i].we[vecs[i].id], vecs[i].id ? vecs[i].a1 : vecs[i].a0,
                1'b0, -1);
      end

      // reset during beat 3 of a write
      req_we = 2'b01; req_addr0 = 13'h0300; req = 2'b01;
      push_beats(1'b0, 1'b1, 13'h0300, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_gnt", 64'(gnt), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_mem_en", 64'(mem_en), 64'(0));
      chk("mid_rst_mem_we", 64'(mem_we), 64'(0));
      chk("mid_rst_addr", 64'(mem_addr), 64'(0));
      chk("mid_rst_wdata", mem_wdata, 64'(0));
      chk("mid_rst_pull", 64'(wdata_pull), 64'(0));
      exp_q.delete();
      req = 2'b00;
      repeat (2) begin
         @(negedge clk);
         chk("mid_rst_done", 64'(done), 64'(0));
         chk("mid_rst_busy_hold", 64'(busy), 64'(0));
      end
      @(posedge clk);
      #1 rst = 1'b0;

      // contention held high: 0,1,0,1 with an idle cycle between each
      req_we = 2'b00; req_addr0 = 13'h0010; req_addr1 = 13'h0100; req = 2'b11;
      do_txn(1'b0, 1'b0, 13'h0010, 1'b1, -1);
      do_txn(1'b1, 1'b0, 13'h0100, 1'b1, -1);
      do_txn(1'b0, 1'b0, 13'h0010, 1'b1, -1);
      do_txn(1'b1, 1'b0, 13'h0100, 1'b0, -1);

      // request dropped at beat 2 still completes
      req_we = 2'b01; req_addr0 = 13'h0400; req = 2'b01;
      do_txn(1'b0, 1'b1, 13'h0400, 1'b1, 3);
      repeat (2) begin
         @(negedge clk);
         chk("after_drop_busy", 64'(busy), 64'(0));
      end

      chk("beats_left", 64'(exp_q.size()), 64'(0));
      chk("reads_left", 64'(rd_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
